// File: rtl/result_stream_serializer.sv
// result_stream_serializer
// Narrows 144-bit systolic-array result beats (9 x 16-bit elements) into
// 32-bit AXI-Stream words for the DMA S2MM channel. It also frames DMA packets
// by raising m_axis_last every PKT_BEATS input beats.
//
// Ports
//   axi_clk       system clock, rising edge
//   axi_clk_n     asynchronous active-low reset
//   s_axis_*      input beat stream (valid/data/ready); element C[i] is data[16i+15:16i]
//   m_axis_*      output word stream (valid/data/last/ready)
//   beat_count    input beats accepted in the current packet
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no beat held; ready for a new beat
// ST_SEND | streaming words of the held beat; word_idx selects the word
module result_stream_serializer #(
   parameter int ELEM_W    = 16,
   parameter int N_ELEM    = 9,
   parameter int OUT_W     = 32,
   parameter int PKT_BEATS = 1
) (
   input  logic                     axi_clk,
   input  logic                     axi_clk_n,
   input  logic                     s_axis_valid,
   input  logic [ELEM_W*N_ELEM-1:0] s_axis_data,
   output logic                     s_axis_ready,
   output logic                     m_axis_valid,
   output logic [OUT_W-1:0]         m_axis_data,
   output logic                     m_axis_last,
   input  logic                     m_axis_ready,
   output logic [15:0]              beat_count
);

   localparam int IN_W  = ELEM_W * N_ELEM;
   localparam int EPW   = OUT_W / ELEM_W;
   localparam int WORDS = (N_ELEM + EPW - 1) / EPW;
   localparam int PAD_W = WORDS * OUT_W;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic [15:0]      PKT_LAST = 16'(PKT_BEATS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IN_W-1:0]    r_buf;
   logic [IDX_W-1:0]   r_word_idx;
   logic [15:0]        r_beat_count;

   logic [PAD_W-1:0]   w_padded;
   logic [OUT_W-1:0]   w_words [WORDS];
   logic               w_last_word;
   logic               w_accept;
   logic               w_hs;
   logic               w_pkt_done;
   logic [15:0]        w_beat_base;

   // Element slots beyond N_ELEM in the final word read as zero.
   always_comb begin
      w_padded             = '0;
      w_padded[IN_W-1:0]   = r_buf;
   end

   always_comb begin
      for (int k = 0; k < WORDS; k++) begin
         w_words[k] = w_padded[k*OUT_W +: OUT_W];
      end
   end

   assign w_last_word = (r_word_idx == LAST_IDX);
   assign m_axis_data = w_words[r_word_idx];
   assign m_axis_last = m_axis_valid && w_last_word && (r_beat_count == PKT_LAST);
   assign w_accept    = s_axis_valid && s_axis_ready;
   assign w_hs        = m_axis_valid && m_axis_ready;
   assign w_pkt_done  = w_hs && m_axis_last;
   assign beat_count  = r_beat_count;

   always_ff @(posedge axi_clk or negedge axi_clk_n) begin
      if (!axi_clk_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // s_axis_ready is opened on the final-word handshake so a waiting beat is
   // taken on the same edge, giving back-to-back beats with no idle cycle.
   always_comb begin
      w_state_nxt  = r_state;
      m_axis_valid = 1'b0;
      s_axis_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            s_axis_ready = 1'b1;
            if (s_axis_valid) begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            m_axis_valid = 1'b1;
            s_axis_ready = w_last_word && m_axis_ready;
            if (m_axis_ready && w_last_word && !s_axis_valid) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Packet wrap and a new-beat increment on the same edge settle to 1.
   assign w_beat_base = w_pkt_done ? 16'd0 : r_beat_count;

   always_ff @(posedge axi_clk or negedge axi_clk_n) begin
      if (!axi_clk_n) begin
         r_buf        <= '0;
         r_word_idx   <= '0;
         r_beat_count <= '0;
      end else begin
         if (w_accept) begin
            r_buf      <= s_axis_data;
            r_word_idx <= '0;
         end else if (w_hs) begin
            r_word_idx <= w_last_word ? '0 : r_word_idx + 1'b1;
         end
         r_beat_count <= w_beat_base + {15'd0, w_accept};
      end
   end

endmodule

// File: tb/tb_result_stream_serializer.sv
module tb_result_stream_serializer;

   localparam int IN_W = 144;

   logic            axi_clk   = 1'b0;
   logic            axi_clk_n = 1'b0;
   logic            s_valid   = 1'b0;
   logic [IN_W-1:0] s_data    = '0;
   logic            m_ready   = 1'b0;

   logic        s_ready1, m_valid1, m_last1;
   logic [31:0] m_data1;
   logic [15:0] bc1;
   logic        s_ready2, m_valid2, m_last2;
   logic [31:0] m_data2;
   logic [15:0] bc2;

   int checks   = 0;
   int failures = 0;

   always #5 axi_clk = ~axi_clk;

   result_stream_serializer #(.PKT_BEATS(1)) u_p1 (
      .axi_clk      (axi_clk),
      .axi_clk_n    (axi_clk_n),
      .s_axis_valid (s_valid),
      .s_axis_data  (s_data),
      .s_axis_ready (s_ready1),
      .m_axis_valid (m_valid1),
      .m_axis_data  (m_data1),
      .m_axis_last  (m_last1),
      .m_axis_ready (m_ready),
      .beat_count   (bc1)
   );

   result_stream_serializer #(.PKT_BEATS(2)) u_p2 (
      .axi_clk      (axi_clk),
      .axi_clk_n    (axi_clk_n),
      .s_axis_valid (s_valid),
      .s_axis_data  (s_data),
      .s_axis_ready (s_ready2),
      .m_axis_valid (m_valid2),
      .m_axis_data  (m_data2),
      .m_axis_last  (m_last2),
      .m_axis_ready (m_ready),
      .beat_count   (bc2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Reference model: queue of words still owed to the DMA, built from whole
   // beats, plus per-instance packet counters.
   typedef struct {
      logic [31:0] data;
      bit          l1;
      bit          l2;
   } word_t;

   word_t       q[$];
   int          cnt1 = 0;
   int          cnt2 = 0;
   bit          acc_flag = 0;
   logic [31:0] got[$];
   bit          got_l2[$];
   int          ready_mode = 0;
   int          pat_idx = 0;

   function automatic logic [15:0] elem(input logic [IN_W-1:0] d, input int i);
      return (i < 9) ? d[16*i +: 16] : 16'h0000;
   endfunction

   always @(negedge axi_clk) begin
      word_t w;
      bit    exp_ready;
      bit    acc;
      if (!axi_clk_n) begin
         q.delete();
         cnt1     = 0;
         cnt2     = 0;
         acc_flag = 0;
         chk1("rst_valid", m_valid1, 1'b0);
         chk ("rst_data",  m_data1, 32'h0);
         chk1("rst_last",  m_last1, 1'b0);
         chk ("rst_bc1",   32'(bc1), 32'd0);
         chk ("rst_bc2",   32'(bc2), 32'd0);
      end else begin
         exp_ready = (q.size() == 0) || (q.size() == 1 && m_ready);
         chk1("s_ready_p1", s_ready1, exp_ready);
         chk1("s_ready_p2", s_ready2, exp_ready);
         chk1("m_valid_p1", m_valid1, q.size() != 0);
         chk1("m_valid_p2", m_valid2, q.size() != 0);
         if (q.size() != 0) begin
            chk ("m_data_p1", m_data1, q[0].data);
            chk ("m_data_p2", m_data2, q[0].data);
            chk1("m_last_p1", m_last1, q[0].l1);
            chk1("m_last_p2", m_last2, q[0].l2);
         end
         chk("beat_count_p1", 32'(bc1), 32'(cnt1));
         chk("beat_count_p2", 32'(bc2), 32'(cnt2));
         acc = s_valid && exp_ready;
         if (q.size() != 0 && m_ready) begin
            w = q.pop_front();
            got.push_back(m_data1);
            got_l2.push_back(m_last2);
            if (w.l1) cnt1 = 0;
            if (w.l2) cnt2 = 0;
         end
         if (acc) begin
            cnt1++;
            cnt2++;
            for (int k = 0; k < 5; k++) begin
               w.data = {elem(s_data, 2*k+1), elem(s_data, 2*k)};
               w.l1   = (k == 4) && (cnt1 == 1);
               w.l2   = (k == 4) && (cnt2 == 2);
               q.push_back(w);
            end
         end
         acc_flag = acc;
      end
   end

   initial begin
      forever begin
         @(posedge axi_clk);
         #1;
         case (ready_mode)
            0: m_ready = 1'b1;
            1: begin
               m_ready = (pat_idx % 3 == 0);
               pat_idx++;
            end
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   function automatic logic [IN_W-1:0] mk_seq(input int base);
      logic [IN_W-1:0] d;
      d = '0;
      for (int i = 0; i < 9; i++) d[16*i +: 16] = 16'(base + i);
      return d;
   endfunction

   function automatic logic [IN_W-1:0] mk_rand();
      logic [IN_W-1:0] d;
      d = '0;
      for (int i = 0; i < 9; i++) d[16*i +: 16] = 16'($urandom_range(0, 65535));
      return d;
   endfunction

   task automatic send_beat(input logic [IN_W-1:0] d);
      bit done;
      done    = 0;
      s_valid = 1'b1;
      s_data  = d;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge axi_clk);
         #1;
         if (acc_flag) done = 1;
      end
      s_valid = 1'b0;
      checks++;
      assert (done) else begin
         failures++;
         $error("FAIL send_timeout observed=not_accepted expected=accepted");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge axi_clk);
         #1;
         n++;
      end
      checks++;
      assert (q.size() == 0) else begin
         failures++;
         $error("FAIL drain_timeout observed=%0d_words_left expected=0", q.size());
      end
      @(posedge axi_clk);
      #1;
   endtask

   logic [31:0] exp1 [5];

   initial begin
      exp1[0] = 32'h00020001;
      exp1[1] = 32'h00040003;
      exp1[2] = 32'h00060005;
      exp1[3] = 32'h00080007;
      exp1[4] = 32'h00000009;

      ready_mode = 0;
      repeat (3) @(posedge axi_clk);
      #1;
      axi_clk_n = 1'b1;
      @(posedge axi_clk);
      #1;

      // PKT_BEATS=2 framing: last on words 10 and 20 only
      got.delete();
      got_l2.delete();
      for (int b = 0; b < 4; b++) send_beat(mk_seq(16'h0100 * (b + 1)));
      drain();
      chk("pkt2_words", 32'(got.size()), 32'd20);
      if (got_l2.size() == 20) begin
         for (int i = 0; i < 20; i++) chk1("pkt2_last_pos", got_l2[i], (i == 9) || (i == 19));
      end

      // single beat, continuous ready
      got.delete();
      send_beat(mk_seq(1));
      drain();
      chk("t1_words", 32'(got.size()), 32'd5);
      if (got.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("t1_word", got[i], exp1[i]);
      end

      // same beat, ready toggling 1,0,0
      pat_idx    = 0;
      ready_mode = 1;
      got.delete();
      send_beat(mk_seq(1));
      drain();
      chk("t2_words", 32'(got.size()), 32'd5);
      if (got.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("t2_word", got[i], exp1[i]);
      end

      // three back-to-back beats, valid held high
      ready_mode = 0;
      got.delete();
      for (int b = 0; b < 3; b++) send_beat(mk_seq(16'h2000 + 16 * b));
      drain();
      chk("t3_words", 32'(got.size()), 32'd15);

      // reset during word 2, then a fresh beat
      send_beat(mk_seq(16'h3000));
      @(posedge axi_clk);
      #1;
      @(posedge axi_clk);
      #1;
      axi_clk_n = 1'b0;
      repeat (2) @(posedge axi_clk);
      #1;
      axi_clk_n = 1'b1;
      got.delete();
      send_beat(mk_seq(16'h1000));
      drain();
      chk("t5_words", 32'(got.size()), 32'd5);
      if (got.size() != 0) chk("t5_first_word", got[0], 32'h10011000);

      // new beat waiting during words 0..3 with stalling ready
      pat_idx    = 0;
      ready_mode = 1;
      got.delete();
      send_beat(mk_seq(16'h4000));
      send_beat(mk_seq(16'h5000));
      drain();
      chk("t6_words", 32'(got.size()), 32'd10);

      // randomized beats, random ready, random gaps
      ready_mode = 2;
      for (int b = 0; b < 40; b++) begin
         send_beat(mk_rand());
         repeat ($urandom_range(0, 3)) begin
            @(posedge axi_clk);
            #1;
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
